// File: rtl/random_seq_checker.sv
// Regenerates the seed-based pseudo-random byte stream and compares it against SRAM readback.
// Optional macro ABORT_ON_ERR_EN: end the run on the first mismatching beat.
module random_seq_checker #(
  parameter logic [7:0] A     = 8'd101,
  parameter logic [7:0] MASK  = 8'h80,
  parameter int         LEN_W = 16,
  parameter int         ERR_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [7:0]       SEED,
  input  logic [LEN_W-1:0] LENGTH,
  input  logic             DIN_VALID,
  input  logic [7:0]       DIN,
  output logic             DIN_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [LEN_W-1:0] FIRST_ERR_IDX,
  output logic [7:0]       FIRST_ERR_EXP,
  output logic [7:0]       FIRST_ERR_GOT
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_reg;
  logic [7:0]       exp_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] idx_reg;
  logic             first_flag_reg;

  logic [15:0] product;
  logic [7:0]  next_word;
  logic        accept;
  logic        mismatch;
  logic        last_beat;
  logic        abort_hit;

  assign product   = {8'd0, exp_reg} * {8'd0, A};
  assign next_word = product[7:0] & MASK;
  assign accept    = (state_reg == ST_RUN) && DIN_VALID;
  assign mismatch  = accept && (DIN != exp_reg);
  assign last_beat = (idx_reg == (len_reg - LEN_W'(1)));

`ifdef ABORT_ON_ERR_EN
  assign abort_hit = mismatch;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      exp_reg        <= '0;
      len_reg        <= '0;
      idx_reg        <= '0;
      first_flag_reg <= 1'b0;
      DIN_READY      <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      ERR_COUNT      <= '0;
      FIRST_ERR_IDX  <= '0;
      FIRST_ERR_EXP  <= '0;
      FIRST_ERR_GOT  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            exp_reg        <= SEED;
            len_reg        <= LENGTH;
            idx_reg        <= '0;
            first_flag_reg <= 1'b0;
            ERR_COUNT      <= '0;
            FIRST_ERR_IDX  <= '0;
            FIRST_ERR_EXP  <= '0;
            FIRST_ERR_GOT  <= '0;
            BUSY           <= 1'b1;
            if (LENGTH != '0) begin
              state_reg <= ST_RUN;
              DIN_READY <= 1'b1;
              PASS      <= 1'b0;
            end else begin
              // Empty run: nothing to compare, so it trivially passes.
              state_reg <= ST_DONE;
              DONE      <= 1'b1;
              PASS      <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (mismatch) begin
              if (!(&ERR_COUNT)) ERR_COUNT <= ERR_COUNT + ERR_W'(1);
              if (!first_flag_reg) begin
                first_flag_reg <= 1'b1;
                FIRST_ERR_IDX  <= idx_reg;
                FIRST_ERR_EXP  <= exp_reg;
                FIRST_ERR_GOT  <= DIN;
              end
            end
            exp_reg <= next_word;
            idx_reg <= idx_reg + LEN_W'(1);
            if (last_beat || abort_hit) begin
              // PASS is settled here so it is already valid while DONE is high.
              state_reg <= ST_DONE;
              DIN_READY <= 1'b0;
              DONE      <= 1'b1;
              PASS      <= !mismatch && (ERR_COUNT == '0);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          DIN_READY <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          DIN_READY <= 1'b0;
          BUSY      <= 1'b0;
          DONE      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_seq_checker.sv
// Scoreboard bench: instance 0 uses the default mask, instance 1 uses MASK=8'hFF.
module tb_random_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, din_valid, din_ready, busy, done, pass;
  logic [7:0] seed [2];
  logic [7:0] din [2];
  logic [15:0] length [2];
  logic [15:0] err_count [2];
  logic [15:0] first_idx [2];
  logic [7:0]  first_exp [2];
  logic [7:0]  first_got [2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [15:0] idx;
    logic [7:0]  e;
    logic [7:0]  g;
  } res_t;

  res_t q0[$];
  res_t q1[$];

  always #5 clk = ~clk;

  random_seq_checker dut0 (
    .CLK(clk), .RST(rst), .START(start[0]), .SEED(seed[0]), .LENGTH(length[0]),
    .DIN_VALID(din_valid[0]), .DIN(din[0]), .DIN_READY(din_ready[0]), .BUSY(busy[0]),
    .DONE(done[0]), .PASS(pass[0]), .ERR_COUNT(err_count[0]), .FIRST_ERR_IDX(first_idx[0]),
    .FIRST_ERR_EXP(first_exp[0]), .FIRST_ERR_GOT(first_got[0])
  );

  random_seq_checker #(.MASK(8'hFF)) dut1 (
    .CLK(clk), .RST(rst), .START(start[1]), .SEED(seed[1]), .LENGTH(length[1]),
    .DIN_VALID(din_valid[1]), .DIN(din[1]), .DIN_READY(din_ready[1]), .BUSY(busy[1]),
    .DONE(done[1]), .PASS(pass[1]), .ERR_COUNT(err_count[1]), .FIRST_ERR_IDX(first_idx[1]),
    .FIRST_ERR_EXP(first_exp[1]), .FIRST_ERR_GOT(first_got[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference word k of the stream, straight from the update rule.
  function automatic logic [7:0] word_at(input logic [7:0] sd, input int k, input logic [7:0] mask);
    logic [7:0] w;
    int p;
    w = sd;
    for (int i = 0; i < k; i++) begin
      p = (int'(w) * 101) % 256;
      w = p[7:0] & mask;
    end
    return w;
  endfunction

  task automatic mon(input int s);
    res_t r;
    bit   have;
    have = 1'b0;
    if (s == 0 && q0.size() > 0) begin r = q0.pop_front(); have = 1'b1; end
    if (s == 1 && q1.size() > 0) begin r = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      total++;
      bad++;
      $display("FAIL done_unexpected inst=%0d", s);
    end else begin
      chk("pass", {31'd0, pass[s]}, {31'd0, r.pass});
      chk("err_count", {16'd0, err_count[s]}, {16'd0, r.err});
      chk("first_idx", {16'd0, first_idx[s]}, {16'd0, r.idx});
      chk("first_exp", {24'd0, first_exp[s]}, {24'd0, r.e});
      chk("first_got", {24'd0, first_got[s]}, {24'd0, r.g});
      $display("txn inst=%0d pass=%0d err=%0d first_idx=%0d exp=%h got=%h",
               s, pass[s], err_count[s], first_idx[s], first_exp[s], first_got[s]);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      always @(negedge clk) if (!rst && done[gi]) mon(gi);
    end
  endgenerate

  // Drives one run and pushes the model's expected result; called #1 after a rising edge.
  task automatic run(input int s, input logic [7:0] sd, input int len, input int err_pct,
                     input int stall_pct, input bit extra_start, input int inj_idx,
                     input logic [7:0] inj_val);
    logic [7:0] data[$];
    logic [7:0] mask, e, g;
    res_t r;
    int consumed, acc, cyc;
    bit v, took;
    mask = (s == 0) ? 8'h80 : 8'hFF;
    r = '{pass: 1'b1, err: 16'd0, idx: 16'd0, e: 8'd0, g: 8'd0};
    consumed = len;
    for (int k = 0; k < len; k++) begin
      e = word_at(sd, k, mask);
      g = e;
      if (k == inj_idx) g = inj_val;
      else if ($urandom_range(99) < err_pct) g = e ^ 8'($urandom_range(1, 255));
      data.push_back(g);
      if (g != e) begin
        if (r.err == 0) begin r.idx = 16'(k); r.e = e; r.g = g; end
        r.err++;
        r.pass = 1'b0;
`ifdef ABORT_ON_ERR_EN
        consumed = k + 1;
        break;
`endif
      end
    end
    if (s == 0) q0.push_back(r); else q1.push_back(r);

    start[s] = 1'b1; seed[s] = sd; length[s] = 16'(len);
    @(posedge clk); #1;
    start[s] = 1'b0; seed[s] = 8'($urandom); length[s] = 16'($urandom);
    if (len == 0) begin
      chk("zero_len_done", {31'd0, done[s]}, 32'd1);
      chk("zero_len_ready", {31'd0, din_ready[s]}, 32'd0);
    end else begin
      acc = 0;
      cyc = 0;
      while (acc < consumed && cyc < len * 8 + 100) begin
        v = ($urandom_range(99) >= stall_pct);
        din_valid[s] = v;
        din[s] = v ? data[acc] : 8'($urandom);
        start[s] = (extra_start && cyc == 2);
        took = v && din_ready[s];
        @(posedge clk); #1;
        cyc++;
        if (took) acc++;
      end
      din_valid[s] = 1'b0;
      start[s] = 1'b0;
      chk("beats_accepted", acc, consumed);
      chk("done_latency", {31'd0, done[s]}, 32'd1);
      chk("ready_in_done", {31'd0, din_ready[s]}, 32'd0);
    end
    @(posedge clk); #1;
    chk("back_to_idle", {31'd0, busy[s]}, 32'd0);
    chk("done_one_cycle", {31'd0, done[s]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = '0; din_valid = '0;
    for (int i = 0; i < 2; i++) begin seed[i] = '0; din[i] = '0; length[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, din_ready[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_done", {31'd0, done[0]}, 32'd0);
    chk("rst_pass", {31'd0, pass[0]}, 32'd0);
    chk("rst_err", {16'd0, err_count[0]}, 32'd0);
    chk("rst_first_idx", {16'd0, first_idx[0]}, 32'd0);
    chk("rst_first_exp", {24'd0, first_exp[0]}, 32'd0);
    chk("rst_first_got", {24'd0, first_got[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the stream rules.
    run(0, 8'h01, 3, 0, 0, 0, -1, 8'h00);
    chk("t1_pass", {31'd0, pass[0]}, 32'd1);
    run(0, 8'h05, 4, 0, 0, 0, 2, 8'h7F);
    chk("t2_err", {16'd0, err_count[0]}, 32'd1);
    chk("t2_first_idx", {16'd0, first_idx[0]}, 32'd2);
    chk("t2_first_exp", {24'd0, first_exp[0]}, 32'h80);
    chk("t2_first_got", {24'd0, first_got[0]}, 32'h7F);
    run(0, 8'h00, 0, 0, 0, 0, -1, 8'h00);
    run(0, 8'h04, 3, 0, 50, 0, -1, 8'h00);
    run(1, 8'h01, 3, 0, 0, 1, -1, 8'h00);
    chk("t6_pass", {31'd0, pass[1]}, 32'd1);

    // Reset in the middle of a run discards partial results.
    start[0] = 1'b1; seed[0] = 8'h05; length[0] = 16'd5;
    @(posedge clk); #1;
    start[0] = 1'b0;
    din_valid[0] = 1'b1; din[0] = 8'h05;
    @(posedge clk); #1;
`ifdef ABORT_ON_ERR_EN
    din[0] = 8'h80;
`else
    din[0] = 8'h00;
`endif
    @(posedge clk); #1;
    din_valid[0] = 1'b0;
`ifdef ABORT_ON_ERR_EN
    chk("t5_live_err", {16'd0, err_count[0]}, 32'd0);
`else
    chk("t5_live_err", {16'd0, err_count[0]}, 32'd1);
`endif
    chk("t5_busy_mid", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_ready", {31'd0, din_ready[0]}, 32'd0);
    chk("t5_busy", {31'd0, busy[0]}, 32'd0);
    chk("t5_pass", {31'd0, pass[0]}, 32'd0);
    chk("t5_err", {16'd0, err_count[0]}, 32'd0);
    run(0, 8'h01, 2, 0, 0, 0, -1, 8'h00);
    chk("t5_rerun_pass", {31'd0, pass[0]}, 32'd1);

    // Randomized runs on both mask variants, including single-beat boundaries.
    run(0, 8'($urandom), 1, 50, 0, 0, -1, 8'h00);
    run(1, 8'($urandom), 1, 50, 0, 0, -1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      run(0, 8'($urandom), $urandom_range(0, 12), 25, 30, 0, -1, 8'h00);
      run(1, 8'($urandom), $urandom_range(0, 12), 25, 30, 0, -1, 8'h00);
    end

    repeat (2) @(posedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
